muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for RV32M multiply/divide operations in the execute stage. It runs alongside the single-cycle ALU. It accepts one M-extension operation at a time and holds the pipeline stalled while it iterates a shared 32-step shift-add / restoring-divide datapath. It then presents the result and destination register to writeback for exactly one cycle.

## Interface
Parameters:
- XLEN, 32: operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  issue request; sampled only in IDLE.
- op_i  in  3  M-op select, RV32M funct3 encoding: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- src1_i  in  32  rs1 operand (multiplicand/dividend).
- src2_i  in  32  rs2 operand (multiplier/divisor).
- destReg_i  in  5  destination register of the issued op.
- flush_i  in  1  pipeline flush; aborts any op in flight.
- busy_o  out  1  high in every state except IDLE.
- stall_o  out  1  pipeline stall request to upstream stages.
- done_o  out  1  one-cycle result-valid pulse.
- res_o  out  32  result; valid only while done_o=1.
- destReg_o  out  5  destination register; valid with done_o, 0 otherwise.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - start_i=1 and flush_i=0 → latch op, destReg and operand magnitudes (abs for signed operands per op), and record result sign.
  - Divide by zero (op≥4, src2=0) → DONE directly; DIV/DIVU give 0xFFFF_FFFF, REM/REMU give src1.
  - Signed overflow (DIV/REM, src1=0x8000_0000, src2=0xFFFF_FFFF) → DONE directly; DIV gives 0x8000_0000, REM gives 0.
  - Any other op → CALC with step counter = 0.
- CALC:
  - One iteration per cycle. Multiply: 64-bit shift-add of the magnitudes. Divide: restoring, 64-bit remainder/quotient register pair.
  - Counter is 5 bits. After step 31 (counter wraps to 0) → SIGN.
- SIGN:
  - Conditionally negate the 64-bit product, or negate quotient/remainder.
  - Product sign = sign1 XOR sign2 for MULH; sign1 only for MULHSU.
  - Quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - Select result: low word for MUL, high word for MULH/MULHSU/MULHU.
  - → DONE.
- DONE: done_o=1, res_o/destReg_o driven; → IDLE unconditionally.
- Back-to-back ops: start_i is not accepted in DONE. It is taken in the following IDLE cycle.
- flush_i=1 in any state → IDLE next cycle; done_o is never asserted for the aborted op. flush_i beats start_i in IDLE.
- start_i outside IDLE is ignored; inputs need not be held after acceptance.

## Timing
- Reset values: state=IDLE, counter=0, busy_o=0, stall_o=0, done_o=0, res_o=0, destReg_o=0.
- Reset mid-operation discards all state. Reset wins over flush_i and start_i.
- stall_o = (IDLE & start_i & ~flush_i) | CALC | SIGN. It is combinational from start_i so the issuing instruction is held in the same cycle. stall_o is 0 in DONE so the pipeline advances with the result.
- Normal latency, accept at cycle 0 (IDLE): CALC in cycles 1–32, SIGN in cycle 33, DONE in cycle 34. done_o is high in cycle 34 only.
- Special-case latency (div-by-zero or overflow): DONE in cycle 1.
- done_o, res_o and destReg_o are registered outputs. destReg_o is 0 whenever done_o=0.

## Structure
- Shared package (akarin.svh): muldivOp enum (funct3 encoding above) and muldiv state enum. The dec2exPkt gains an isMulDiv flag and a muldivOp field.
- Sub-module muldiv_step: combinational single-iteration datapath. Inputs: op class, 64-bit accumulator, 32-bit operand. Outputs: next accumulator. Instantiated once.
- All control (FSM, counter, sign tracking, special-case detection) lives in muldiv_seq.

## Test plan
- MUL 7×6 issued at cycle 0 → stall_o high cycles 0–33, done_o pulse at cycle 34, res_o=42, destReg_o=issued reg.
- MULH 0x8000_0000×0x8000_0000 → res_o=0x4000_0000. MULHSU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFF. MULHU same operands → 0xFFFF_FFFE.
- DIV −7/2 → res_o=0xFFFF_FFFD (−3). REM −7/2 → 0xFFFF_FFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 5/0 → done_o at cycle 1, res_o=0xFFFF_FFFF. REM 5/0 → 5. DIV 0x8000_0000/−1 → 0x8000_0000 at cycle 1.
- flush_i at cycle 10 of a DIV → IDLE at cycle 11, no done_o. A new MUL issued at cycle 11 completes at cycle 45.
- rst asserted at cycle 20 of a MUL → all outputs 0 next cycle. start_i pulsed in CALC is ignored, and exactly one done_o is seen.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: op encoding, FSM states,
// datapath class and the decode-to-execute fields that steer an op here.
package muldiv_seq_pkg;

   // RV32M funct3 encoding
   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_SIGN,
      S_DONE
   } muldiv_state_e;

   typedef enum logic {
      CLS_MUL,
      CLS_DIV
   } muldiv_class_e;

   typedef struct packed {
      logic       is_mul_div;
      muldiv_op_e muldiv_op;
   } dec2ex_muldiv_t;

   function automatic muldiv_class_e op_class(input muldiv_op_e op);
      return op[2] ? CLS_DIV : CLS_MUL;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// divide step on a {high, low} 64-bit accumulator.
module muldiv_step
   import muldiv_seq_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  muldiv_class_e         op_cls,
   input  logic [2*XLEN-1:0]     acc,
   input  logic [XLEN-1:0]       operand,
   output logic [2*XLEN-1:0]     acc_next
);

   logic [XLEN:0] sum;
   logic [XLEN:0] diff;

   always_comb begin
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
      // Trial subtract of the divisor from the remainder shifted left by one.
      diff     = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
      acc_next = '0;
      if (op_cls == CLS_DIV) begin
         if (diff[XLEN])
            acc_next = {acc[2*XLEN-2:0], 1'b0};
         else
            acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
         acc_next = {sum, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: stalls the pipeline for 32 iterations of the
// shared step datapath, fixes signs, then presents a one-cycle result.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   input  logic [4:0]      destReg_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] res_o,
   output logic [4:0]      destReg_o
);

   muldiv_state_e     state, state_next;
   logic [4:0]        count;
   muldiv_op_e        op_q;
   logic [4:0]        dest_q;
   logic              neg_q;
   logic [2*XLEN-1:0] acc, acc_step;
   logic [XLEN-1:0]   operand;
   logic              done_q;
   logic [XLEN-1:0]   res_q;
   logic [4:0]        dest_out_q;

   muldiv_op_e        op_in;
   logic              accept, sign1, sign2, neg_in, div_in;
   logic              div_zero, ovf, special;
   logic [XLEN-1:0]   mag1, mag2, special_res, sign_res;
   logic [2*XLEN-1:0] prod;

   always_comb begin
      op_in       = muldiv_op_e'(op_i);
      div_in      = (op_class(op_in) == CLS_DIV);
      accept      = (state == S_IDLE) && start_i && !flush_i;
      sign1       = src1_i[XLEN-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
      sign2       = src2_i[XLEN-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
      mag1        = sign1 ? -src1_i : src1_i;
      mag2        = sign2 ? -src2_i : src2_i;
      neg_in      = 1'b0;
      case (op_in)
         OP_MULH, OP_DIV: neg_in = sign1 ^ sign2;
         OP_MULHSU, OP_REM: neg_in = sign1;
         default: neg_in = 1'b0;
      endcase
      div_zero    = div_in && (src2_i == '0);
      ovf         = (op_in inside {OP_DIV, OP_REM}) &&
                    (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1);
      special     = div_zero || ovf;
      special_res = '0;
      if (div_zero)
         special_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : src1_i;
      else if (ovf)
         special_res = (op_in == OP_DIV) ? src1_i : '0;
   end

   always_comb begin
      prod     = neg_q ? -acc : acc;
      sign_res = '0;
      case (op_q)
         OP_MUL:                     sign_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: sign_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:            sign_res = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
         default:                    sign_res = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      endcase
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .op_cls   (op_class(op_q)),
      .acc      (acc),
      .operand  (operand),
      .acc_next (acc_step)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush_i) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start_i) state_next = special ? S_DONE : S_CALC;
            S_CALC: if (count == 5'd31) state_next = S_SIGN;
            S_SIGN: state_next = S_DONE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Result registers are loaded only on the transition into DONE and cleared
   // otherwise, so done_o and destReg_o are plain flops with no gating.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         op_q       <= OP_MUL;
         dest_q     <= '0;
         neg_q      <= 1'b0;
         acc        <= '0;
         operand    <= '0;
         done_q     <= 1'b0;
         res_q      <= '0;
         dest_out_q <= '0;
      end else begin
         done_q     <= 1'b0;
         res_q      <= '0;
         dest_out_q <= '0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q    <= op_in;
                  dest_q  <= destReg_i;
                  neg_q   <= neg_in;
                  count   <= '0;
                  acc     <= {{XLEN{1'b0}}, (div_in ? mag1 : mag2)};
                  operand <= div_in ? mag2 : mag1;
                  if (special) begin
                     done_q     <= 1'b1;
                     res_q      <= special_res;
                     dest_out_q <= destReg_i;
                  end
               end
            end
            S_CALC: begin
               acc   <= acc_step;
               count <= count + 5'd1;
            end
            S_SIGN: begin
               if (!flush_i) begin
                  done_q     <= 1'b1;
                  res_q      <= sign_res;
                  dest_out_q <= dest_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o    = (state != S_IDLE);
   assign stall_o   = accept || (state == S_CALC) || (state == S_SIGN);
   assign done_o    = done_q;
   assign res_o     = res_q;
   assign destReg_o = dest_out_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table for results/latency plus
// hand-written flush, reset, back-to-back and ignored-start sequences.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst, start_i, flush_i;
   logic [2:0]  op_i;
   logic [31:0] src1_i, src2_i;
   logic [4:0]  destReg_i;
   logic        busy_o, stall_o, done_o;
   logic [31:0] res_o;
   logic [4:0]  destReg_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   muldiv_seq #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .op_i      (op_i),
      .src1_i    (src1_i),
      .src2_i    (src2_i),
      .destReg_i (destReg_i),
      .flush_i   (flush_i),
      .busy_o    (busy_o),
      .stall_o   (stall_o),
      .done_o    (done_o),
      .res_o     (res_o),
      .destReg_o (destReg_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] exp, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd);
      start_i = 1'b1; op_i = op; src1_i = a; src2_i = b; destReg_i = rd;
   endtask

   // Advances from the issue cycle until done_o is seen (bounded); start_i is dropped
   // after the accepting edge. Counts non-done cycles in which stall_o was low.
   task automatic wait_done(input int max, output int lat, output int gaps);
      lat = 0; gaps = 0;
      do begin
         @(posedge clk); #1;
         start_i = 1'b0;
         #1;
         lat++;
         if (!done_o && !stall_o) gaps++;
      end while (!done_o && lat < max);
   endtask

   initial begin
      int lat, gaps, pulses, done_cyc;
      logic [31:0] cap_res;
      logic [4:0]  cap_rd;

      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      op_i = '0; src1_i = '0; src2_i = '0; destReg_i = '0;

      vecs.push_back(mk(3'd0, 32'd7,         32'd6,         5'd1,  32'd42,        34));
      vecs.push_back(mk(3'd0, 32'hFFFF_FFFD, 32'd5,         5'd2,  32'hFFFF_FFF1, 34));
      vecs.push_back(mk(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'd1,         34));
      vecs.push_back(mk(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 34));
      vecs.push_back(mk(3'd1, 32'hFFFF_FFFD, 32'd5,         5'd5,  32'hFFFF_FFFF, 34));
      vecs.push_back(mk(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 34));
      vecs.push_back(mk(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34));
      vecs.push_back(mk(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 34));
      vecs.push_back(mk(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 34));
      vecs.push_back(mk(3'd4, 32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 34));
      vecs.push_back(mk(3'd6, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'd1,         34));
      vecs.push_back(mk(3'd5, 32'd100,       32'd7,         5'd12, 32'd14,        34));
      vecs.push_back(mk(3'd7, 32'd100,       32'd7,         5'd13, 32'd2,         34));
      vecs.push_back(mk(3'd5, 32'hFFFF_FFFF, 32'd1,         5'd14, 32'hFFFF_FFFF, 34));
      vecs.push_back(mk(3'd7, 32'd5,         32'd7,         5'd15, 32'd5,         34));
      vecs.push_back(mk(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         34));
      vecs.push_back(mk(3'd4, 32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF, 1));
      vecs.push_back(mk(3'd6, 32'd5,         32'd0,         5'd18, 32'd5,         1));
      vecs.push_back(mk(3'd5, 32'd9,         32'd0,         5'd19, 32'hFFFF_FFFF, 1));
      vecs.push_back(mk(3'd7, 32'd9,         32'd0,         5'd20, 32'd9,         1));
      vecs.push_back(mk(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1));
      vecs.push_back(mk(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'd0,         1));

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  {31'd0, busy_o},  32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      check("rst_done",  {31'd0, done_o},  32'd0);
      check("rst_res",   res_o,            32'd0);
      check("rst_dest",  {27'd0, destReg_o}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         drive_start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
         #1;
         check($sformatf("v%0d_issue_stall", i), {31'd0, stall_o}, 32'd1);
         wait_done(100, lat, gaps);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_res", i), res_o, vecs[i].exp);
         check($sformatf("v%0d_dest", i), {27'd0, destReg_o}, {27'd0, vecs[i].rd});
         check($sformatf("v%0d_stall_gaps", i), gaps, 0);
         check($sformatf("v%0d_done_stall", i), {31'd0, stall_o}, 32'd0);
         @(posedge clk); #2;
         check($sformatf("v%0d_pulse_end", i), {26'd0, done_o, destReg_o}, 32'd0);
      end

      // Flush beats start in IDLE
      drive_start(3'd0, 32'd3, 32'd3, 5'd1);
      flush_i = 1'b1;
      #1;
      check("flush_start_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      #1;
      check("flush_start_busy", {31'd0, busy_o}, 32'd0);

      // Flush at cycle 10 of a DIV, new MUL issued at cycle 11
      drive_start(3'd4, 32'd1000, 32'd3, 5'd9);
      pulses = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         #1;
         if (done_o) pulses++;
      end
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      #1;
      if (done_o) pulses++;
      check("flush_idle_busy", {31'd0, busy_o}, 32'd0);
      check("flush_no_done", pulses, 0);
      drive_start(3'd0, 32'd11, 32'd13, 5'd25);
      wait_done(100, lat, gaps);
      check("flush_mul_lat", 11 + lat, 45);
      check("flush_mul_res", res_o, 32'd143);
      check("flush_mul_dest", {27'd0, destReg_o}, 32'd25);

      // Reset at cycle 20 of a MUL
      @(posedge clk); #1;
      drive_start(3'd0, 32'd7, 32'd6, 5'd2);
      pulses = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         #1;
         if (done_o) pulses++;
      end
      rst = 1'b1;
      @(posedge clk); #2;
      check("rstmid_busy",  {31'd0, busy_o},  32'd0);
      check("rstmid_stall", {31'd0, stall_o}, 32'd0);
      check("rstmid_done",  {31'd0, done_o},  32'd0);
      check("rstmid_res",   res_o,            32'd0);
      check("rstmid_dest",  {27'd0, destReg_o}, 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #2;
         if (done_o) pulses++;
      end
      check("rstmid_no_done", pulses, 0);

      // start_i pulsed during CALC is ignored
      drive_start(3'd0, 32'd9, 32'd9, 5'd3);
      pulses = 0; done_cyc = 0; cap_res = '0; cap_rd = '0;
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk); #1;
         if (c == 1 || c == 6) start_i = 1'b0;
         if (c == 5) drive_start(3'd5, 32'd50, 32'd5, 5'd9);
         #1;
         if (done_o) begin
            pulses++; done_cyc = c; cap_res = res_o; cap_rd = destReg_o;
         end
      end
      check("ign_pulses", pulses, 1);
      check("ign_cycle", done_cyc, 34);
      check("ign_res", cap_res, 32'd81);
      check("ign_dest", {27'd0, cap_rd}, 32'd3);

      // Back-to-back: start held high through DONE, taken in the next IDLE
      drive_start(3'd0, 32'd3, 32'd4, 5'd7);
      lat = 0;
      do begin
         @(posedge clk); #2;
         lat++;
      end while (!done_o && lat < 100);
      check("b2b_lat1", lat, 34);
      check("b2b_res1", res_o, 32'd12);
      check("b2b_done_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #2;
      check("b2b_idle_done", {31'd0, done_o}, 32'd0);
      check("b2b_idle_busy", {31'd0, busy_o}, 32'd0);
      check("b2b_idle_stall", {31'd0, stall_o}, 32'd1);
      wait_done(100, lat, gaps);
      check("b2b_lat2", 35 + lat, 69);
      check("b2b_res2", res_o, 32'd12);
      check("b2b_dest2", {27'd0, destReg_o}, 32'd7);
      @(posedge clk); #2;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
